// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with start/busy/valid handshake.
// Shift-add multiply and restoring divide share one 64-bit accumulator, one bit per cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic            kill,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] dataD
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] op;
  logic [31:0] m;
  logic [63:0] acc, acc_nx, p;
  logic neg;
  logic [4:0] cnt;
  logic is_div, neg_a, neg_b, neg_in, div_zero, ovf, special;
  logic [31:0] abs_a, abs_b, spec_res, q_sel, div_res, res;
  logic [32:0] mul_sum, trial;
  always_comb begin
    is_div = funct3[2];
    neg_a = dataA[31] & (funct3 == 3'd1 || funct3 == 3'd2 || funct3 == 3'd4 || funct3 == 3'd6);
    neg_b = dataB[31] & (funct3 == 3'd1 || funct3 == 3'd4 || funct3 == 3'd6);
    abs_a = neg_a ? -dataA : dataA;
    abs_b = neg_b ? -dataB : dataB;
    div_zero = is_div && dataB == 32'd0;
    ovf = (funct3 == 3'd4 || funct3 == 3'd6) && dataA == 32'h8000_0000 && dataB == 32'hFFFF_FFFF;
    special = div_zero || ovf;
    spec_res = div_zero ? (funct3[1] ? dataA : 32'hFFFF_FFFF) : (funct3[1] ? 32'd0 : 32'h8000_0000);
    // remainder follows the dividend's sign; everything else uses the sign product
    neg_in = (is_div && funct3[1]) ? neg_a : neg_a ^ neg_b;
  end
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    trial = {acc[63:32], acc[31]} - {1'b0, m};
    acc_nx = op[2] ? (trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1})
                   : {mul_sum, acc[31:1]};
    p = neg ? -acc_nx : acc_nx;
    q_sel = op[1] ? acc_nx[63:32] : acc_nx[31:0];
    div_res = neg ? -q_sel : q_sel;
    res = op[2] ? div_res : (op[1:0] == 2'd0 ? p[31:0] : p[63:32]);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? (special ? DONE : CALC) : IDLE;
      CALC: state_nx = cnt == 5'd0 ? DONE : CALC;
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= 3'd0;
      m <= 32'd0;
      acc <= 64'd0;
      neg <= 1'b0;
      cnt <= 5'd0;
      dataD <= 32'd0;
    end else if (!kill) begin
      if (state == IDLE && start) begin
        op <= funct3;
        m <= is_div ? abs_b : abs_a;
        acc <= {32'd0, is_div ? abs_a : abs_b};
        neg <= neg_in;
        cnt <= 5'd31;
        if (special) dataD <= spec_res;
      end else if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd0) dataD <= res;
      end
    end
  end
  assign busy = state != IDLE;
  assign valid = state == DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;
  logic clk = 0, rst_n = 0, start = 0, kill = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] dataA = 0, dataB = 0, dataD, last = 0;
  logic busy, valid;
  int nchk = 0, nerr = 0;

  muldiv_unit dut (.clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .dataA(dataA),
                   .dataB(dataB), .kill(kill), .busy(busy), .valid(valid), .dataD(dataD));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    logic [63:0] pr;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (f)
      3'd0: begin pr = ua * ub; return pr[31:0]; end
      3'd1: begin pr = sa * sb; return pr[63:32]; end
      3'd2: begin pr = sa * ub; return pr[63:32]; end
      3'd3: begin pr = ua * ub; return pr[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb; return r[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; r = ua / ub; return r[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb; return r[31:0];
      end
      default: begin if (b == 0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int mid_start);
    logic [31:0] exp;
    int lat_exp, lat;
    exp = ref_res(f, a, b);
    lat_exp = (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32;
    @(negedge clk);
    start = 1; funct3 = f; dataA = a; dataB = b;
    @(negedge clk);
    start = 0; funct3 = 3'($urandom); dataA = $urandom; dataB = $urandom;
    lat = 0;
    while (!valid && lat < 40) begin
      start = (lat == mid_start);
      @(negedge clk);
      lat++;
    end
    start = 0;
    chk({tag, " latency"}, lat, lat_exp);
    chk({tag, " dataD"}, dataD, exp);
    @(negedge clk);
    chk({tag, " valid pulse"}, {30'd0, busy, valid}, 32'd0);
    last = exp;
  endtask

  initial begin
    int vh;
    logic [2:0] f;
    logic [31:0] a, b;
    #12;
    chk("reset", {busy, valid, 30'd0} | dataD, 32'd0);
    @(negedge clk); rst_n = 1;

    run_op("mul 7x6", 3'd0, 32'd7, 32'd6, -1);
    run_op("mulhu max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("mulh -2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, -1);
    run_op("mulhsu -1xmax", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("mul -2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, -1);
    run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("divu 100/7", 3'd5, 32'd100, 32'd7, -1);
    run_op("remu 100/7", 3'd7, 32'd100, 32'd7, -1);
    run_op("div 5/0", 3'd4, 32'd5, 32'd0, -1);
    run_op("remu 5/0", 3'd7, 32'd5, 32'd0, -1);
    run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("start while busy", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    @(negedge clk);
    start = 1; funct3 = 3'd0; dataA = 32'd3; dataB = 32'd5;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    kill = 1;
    @(negedge clk); kill = 0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    chk("kill hold", dataD, last);
    vh = 0;
    repeat (40) begin @(negedge clk); if (valid) vh++; end
    chk("kill no valid", vh, 0);
    chk("kill hold later", dataD, last);

    start = 1; kill = 1; funct3 = 3'd5; dataA = 32'd8; dataB = 32'd2;
    @(negedge clk); start = 0; kill = 0;
    chk("kill+start dropped", {30'd0, busy, valid}, 32'd0);

    start = 1; funct3 = 3'd5; dataA = 32'd1000; dataB = 32'd7;
    @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("async reset", {busy, valid, 30'd0} | dataD, 32'd0);
    @(negedge clk); rst_n = 1;
    last = 0;
    run_op("divu 9/3 after reset", 3'd5, 32'd9, 32'd3, -1);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = {1'b1, 31'($urandom)};
        default: ;
      endcase
      run_op("random", f, a, b, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
